// File: rtl/snake_scan_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : snake_scan_scheduler                                    |
// | Purpose  : Scans the snake segment RAM once per tile row, streams  |
// |            segments on that row to the renderer, and shares the    |
// |            single-port RAM with the game engine.                   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module snake_scan_scheduler #(
  parameter int MAX_LEN = 64,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              row_start,
  input  logic [3:0]        row_y,
  input  logic [ADDR_W:0]   snake_len,
  input  logic [ADDR_W-1:0] head_ptr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [10:0]       mem_rdata,
  input  logic              game_req,
  output logic              game_gnt,
  input  logic              game_done,
  output logic [4:0]        seg_x,
  output logic [3:0]        seg_y,
  output logic [1:0]        seg_dir,
  output logic              seg_first,
  output logic              seg_last,
  output logic              seg_valid,
  output logic              busy,
  output logic              overrun
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SCAN  = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_GAME  = 2'd3;

  localparam logic [ADDR_W:0] c_MAX_LEN = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0] c_ONE     = (ADDR_W+1)'(1);

  logic [1:0]        r_state;
  logic [3:0]        r_ry;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_hp;
  logic [ADDR_W-1:0] r_idx;
  logic              r_pending;
  logic [3:0]        r_pend_row;
  logic              r_overrun;

  // Read pipeline: describes the RAM word arriving on mem_rdata this cycle
  logic              r_p_vld;
  logic              r_p_first;
  logic              r_p_last;

  logic [4:0]        r_seg_x;
  logic [3:0]        r_seg_y;
  logic [1:0]        r_seg_dir;
  logic              r_seg_first;
  logic              r_seg_last;
  logic              r_seg_valid;

  logic              w_scanning;
  logic              w_abort;
  logic              w_start;
  logic [3:0]        w_start_row;
  logic [ADDR_W:0]   w_len_clamp;
  logic              w_last_rd;

  // Scan entry decode; a new row_start always wins over a stored pending row
  always_comb begin
    w_scanning  = (r_state == c_SCAN) || (r_state == c_DRAIN);
    w_abort     = row_start && w_scanning;
    w_start_row = row_start ? row_y : r_pend_row;
    w_len_clamp = (snake_len > c_MAX_LEN) ? c_MAX_LEN : snake_len;
    w_last_rd   = ({1'b0, r_idx} == (r_len - c_ONE));
    w_start     = 1'b0;
    case (r_state)
      c_IDLE:  w_start = row_start || r_pending;
      c_GAME:  w_start = game_done && (row_start || r_pending);
      default: w_start = row_start;
    endcase
  end

  // Main sequencer: scan latch/advance, game grant, pending and overrun tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_ry       <= '0;
      r_len      <= '0;
      r_hp       <= '0;
      r_idx      <= '0;
      r_pending  <= 1'b0;
      r_pend_row <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (row_start && (w_scanning || r_pending)) begin
        r_overrun <= 1'b1;
      end
      if (w_start) begin
        r_ry      <= w_start_row;
        r_len     <= w_len_clamp;
        r_hp      <= head_ptr;
        r_idx     <= '0;
        r_pending <= 1'b0;
        r_state   <= (w_len_clamp == '0) ? c_IDLE : c_SCAN;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (game_req) begin
              r_state <= c_GAME;
            end
          end
          c_SCAN: begin
            if (w_last_rd) begin
              r_state <= c_DRAIN;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          c_DRAIN: begin
            r_state <= c_IDLE;
          end
          c_GAME: begin
            // Rows requested while the game owns the RAM are deferred
            if (row_start) begin
              r_pending  <= 1'b1;
              r_pend_row <= row_y;
            end
            if (game_done) begin
              r_state <= c_IDLE;
            end
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

  // Segment output stage; an abort discards everything still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_vld     <= 1'b0;
      r_p_first   <= 1'b0;
      r_p_last    <= 1'b0;
      r_seg_x     <= '0;
      r_seg_y     <= '0;
      r_seg_dir   <= '0;
      r_seg_first <= 1'b0;
      r_seg_last  <= 1'b0;
      r_seg_valid <= 1'b0;
    end else begin
      r_p_vld   <= (r_state == c_SCAN) && !w_abort;
      r_p_first <= (r_idx == '0);
      r_p_last  <= w_last_rd;
      if (r_p_vld && !w_abort) begin
        r_seg_x     <= mem_rdata[10:6];
        r_seg_y     <= mem_rdata[5:2];
        r_seg_dir   <= mem_rdata[1:0];
        r_seg_first <= r_p_first;
        r_seg_last  <= r_p_last;
        r_seg_valid <= (mem_rdata[5:2] == r_ry);
      end else begin
        r_seg_first <= 1'b0;
        r_seg_last  <= 1'b0;
        r_seg_valid <= 1'b0;
      end
    end
  end

  assign mem_rd    = (r_state == c_SCAN);
  assign mem_addr  = mem_rd ? (r_hp + r_idx) : '0;
  assign game_gnt  = (r_state == c_GAME);
  assign busy      = w_scanning || r_pending;
  assign overrun   = r_overrun;
  assign seg_x     = r_seg_x;
  assign seg_y     = r_seg_y;
  assign seg_dir   = r_seg_dir;
  assign seg_first = r_seg_first;
  assign seg_last  = r_seg_last;
  assign seg_valid = r_seg_valid;

endmodule
`default_nettype wire

// File: doc/snake_scan_scheduler.md
Name: snake_scan_scheduler

Overview:
- Sequences per-tile-row prefetch of the snake segment RAM and streams matching segments to the VGA renderer's snake_* inputs.
- Arbitrates the single-port segment RAM between that row scan and the game engine, which needs exclusive access to move, grow or reset the snake.
- Sits between the segment RAM, the game logic and vga; the row trigger comes from the vga_sync-derived tile-row change.

Parameters:
MAX_LEN, 64, segment RAM depth (power of 2); circular buffer of segments
ADDR_W, 6, log2(MAX_LEN)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
row_start  in  1  single-cycle pulse: renderer begins prefetch for tile row row_y
row_y  in  4  target tile row, sampled with row_start
snake_len  in  ADDR_W+1  current segment count, 0..MAX_LEN
head_ptr  in  ADDR_W  RAM index of head segment
mem_addr  out  ADDR_W  scan read address
mem_rd  out  1  scan read strobe
mem_rdata  in  11  {x[10:6], y[5:2], dir[1:0]}, valid one cycle after mem_rd
game_req  in  1  game engine requests RAM; level, held until granted
game_gnt  out  1  game owns RAM; external mux selects game port while high
game_done  in  1  single-cycle pulse, game releases RAM
seg_x  out  5  segment tile x
seg_y  out  4  segment tile y
seg_dir  out  2  segment direction
seg_first  out  1  segment is head
seg_last  out  1  segment is tail
seg_valid  out  1  segment fields valid this cycle
busy  out  1  scan in progress or pending
overrun  out  1  sticky: row_start arrived while a scan was active or pending

Behaviour:
- One clock, synchronous active-high reset. Reset clears everything: state IDLE, all outputs 0, pending 0, overrun 0, idx 0. Reset mid-scan or mid-grant aborts immediately. game_gnt drops the cycle after reset is sampled.
- State machine:
  - IDLE: if row_start or pending, go to SCAN. Else if game_req, go to GAME and assert game_gnt from the next cycle. row_start/pending beats game_req in the same cycle.
  - SCAN entry: latch row_y → ry, snake_len → len, head_ptr → hp; idx = 0; clear pending. If len == 0, return to IDLE with no reads and no seg_valid.
  - SCAN: each cycle mem_rd = 1 and mem_addr = (hp + idx) mod MAX_LEN (natural ADDR_W wrap); idx++. After the read with idx == len-1, go to DRAIN.
  - DRAIN: one cycle for the final read data, then IDLE.
  - GAME: game_gnt = 1 and mem_rd = 0 until game_done is sampled. game_gnt deasserts the next cycle; state goes to IDLE, or straight to SCAN if pending.
- Read pipeline, 1-cycle latency: the cycle after each read, the seg_* outputs are registered with x/y/dir from mem_rdata.
  - seg_first = (read idx == 0).
  - seg_last = (read idx == len-1).
  - seg_valid = (y == ry). Non-matching segments output seg_valid = 0, fields don't-care.
- Total scan latency: row_start → first seg_valid candidate in 2 cycles; scan completes in len+2 cycles. Must be ≤ 32×800 clocks per tile row, which MAX_LEN=64 guarantees.
- row_start during GAME: set pending; the scan starts in the cycle game_gnt drops.
- row_start during SCAN/DRAIN, or while pending already set: set overrun. Abort the current scan and restart in SCAN with the new row_y on the next cycle; in-flight data from the aborted scan is suppressed (seg_valid = 0).
- game_req is never starved: it is granted on the first IDLE cycle with no row_start/pending.
- game_done outside GAME is ignored.
- busy = state != IDLE && state != GAME, or pending.
- snake_len > MAX_LEN is clamped to MAX_LEN at latch.

Test Plan:
- Reset then len=3, hp=62, row_start with row_y=5, RAM[62]={3,5,0}, RAM[63]={4,5,3}, RAM[0]={4,6,1} → mem_addr 62,63,0 on consecutive cycles; seg_valid 1,1,0; seg_first only on the first, seg_last on the third; busy drops at cycle 5.
- len=0, row_start → no mem_rd, no seg_valid, IDLE after 1 cycle.
- game_req and row_start in the same IDLE cycle → scan runs first; game_gnt rises the cycle after DRAIN→IDLE; game_done → gnt low next cycle.
- row_start during GAME → pending, busy=1, no mem_rd; game_done → scan starts the cycle gnt drops; overrun stays 0.
- Second row_start in mid-scan (idx=2) → overrun=1, scan restarts at hp with the new row_y; stale data produces no seg_valid.
- Assert rst mid-GAME and mid-SCAN → next cycle all outputs 0, state IDLE, overrun cleared.
